dmem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single byte-enabled data-memory port between requester 0 (CPU M-stage load/store) and requester 1 (DMA / debug loader). It sits between the requesters and the word-addressed data memory. That memory has a combinational read and commits a write on the clock edge whenever any byte-enable bit is set. The arbiter grants at most one beat per cycle, supports locked bursts with a bounded lock length, and returns registered read data one cycle after grant.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_pick.sv | 29 ++
 rtl/dmem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Round-robin selection is enabled by defining DMEM_ARB_RR_EN.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } arb_state_e;

   localparam int unsigned BYTEEN_W  = 4;
   localparam logic [31:0] WORD_MASK = 32'hffff_fffc;

   function automatic logic is_read(input logic [BYTEEN_W-1:0] be);
      return be == '0;
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select producing a one-hot grant.
// last_i = 1 means requester 1 was granted last, so requester 0 wins a tie.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic [1:0] state_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = '0;
      case (state_i)
         IDLE: begin
            if (req0_i && (!req1_i || last_i)) begin
               gnt_o[0] = 1'b1;
            end else if (req1_i) begin
               gnt_o[1] = 1'b1;
            end
         end
         OWN0:    gnt_o[0] = req0_i;
         OWN1:    gnt_o[1] = req1_i;
         default: gnt_o    = '0;
      endcase
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the byte-enabled data-memory port with locked bursts.
// Define DMEM_ARB_RR_EN for round-robin selection in IDLE; default is fixed r0-over-r1.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX_LOCK = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                r0_req,
   input  logic                r0_lock,
   input  logic [31:0]         r0_addr,
   input  logic [31:0]         r0_wdata,
   input  logic [BYTEEN_W-1:0] r0_byteen,
   input  logic                r1_req,
   input  logic                r1_lock,
   input  logic [31:0]         r1_addr,
   input  logic [31:0]         r1_wdata,
   input  logic [BYTEEN_W-1:0] r1_byteen,
   output logic                r0_gnt,
   output logic                r1_gnt,
   output logic                r0_rvalid,
   output logic                r1_rvalid,
   output logic [31:0]         r0_rdata,
   output logic [31:0]         r1_rdata,
   output logic [31:0]         mem_addr,
   output logic [31:0]         mem_wdata,
   output logic [BYTEEN_W-1:0] mem_byteen,
   input  logic [31:0]         mem_rdata,
   output logic [1:0]          owner
);

   localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

   arb_state_e  state_q, state_d;
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   logic        r0_rvalid_q, r1_rvalid_q;
   logic [31:0] r0_rdata_q, r1_rdata_q;
   logic        last;
   logic [1:0]  pick_gnt;
   logic        own_gnt, own_lock, other_req;

`ifdef DMEM_ARB_RR_EN
   logic last_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_q <= 1'b1;
      end else if (r0_gnt || r1_gnt) begin
         last_q <= r1_gnt;
      end
   end

   assign last = last_q;
`else
   // Pinning "r1 granted last" turns the round-robin pick into fixed r0 priority.
   assign last = 1'b1;
`endif

   dmem_arb_pick u_pick (
      .req0_i  (r0_req),
      .req1_i  (r1_req),
      .state_i (state_q),
      .last_i  (last),
      .gnt_o   (pick_gnt)
   );

   // No grant is ever issued while reset is held low.
   assign r0_gnt = pick_gnt[0] & reset;
   assign r1_gnt = pick_gnt[1] & reset;

   always_comb begin
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_byteen = '0;
      if (r0_gnt) begin
         mem_addr   = r0_addr & WORD_MASK;
         mem_wdata  = r0_wdata;
         mem_byteen = r0_byteen;
      end else if (r1_gnt) begin
         mem_addr   = r1_addr & WORD_MASK;
         mem_wdata  = r1_wdata;
         mem_byteen = r1_byteen;
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      own_gnt    = (state_q == OWN1) ? r1_gnt  : r0_gnt;
      own_lock   = (state_q == OWN1) ? r1_lock : r0_lock;
      other_req  = (state_q == OWN1) ? r0_req  : r1_req;
      case (state_q)
         IDLE: begin
            if (r0_gnt && r0_lock) begin
               state_d    = OWN0;
               lock_cnt_d = 8'd1;
            end else if (r1_gnt && r1_lock) begin
               state_d    = OWN1;
               lock_cnt_d = 8'd1;
            end
         end
         OWN0, OWN1: begin
            if (!own_gnt || !own_lock || (lock_cnt_q == LOCK_MAX && other_req)) begin
               state_d = IDLE;
            end else if (lock_cnt_q != LOCK_MAX) begin
               lock_cnt_d = lock_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         lock_cnt_q  <= '0;
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
         r0_rdata_q  <= '0;
         r1_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         lock_cnt_q  <= lock_cnt_d;
         r0_rvalid_q <= r0_gnt && is_read(r0_byteen);
         r1_rvalid_q <= r1_gnt && is_read(r1_byteen);
         if (r0_gnt && is_read(r0_byteen)) r0_rdata_q <= mem_rdata;
         if (r1_gnt && is_read(r1_byteen)) r1_rdata_q <= mem_rdata;
      end
   end

   assign r0_rvalid = r0_rvalid_q;
   assign r1_rvalid = r1_rvalid_q;
   assign r0_rdata  = r0_rdata_q;
   assign r1_rdata  = r1_rdata_q;
   assign owner     = state_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a small behavioural memory.
// Expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        r0_req, r0_lock, r1_req, r1_lock;
   logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic [3:0]  r0_byteen, r1_byteen;
   logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
   logic [31:0] r0_rdata, r1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_byteen;
   logic [1:0]  owner;

   logic        pre_en;
   logic [31:0] pre_addr, pre_data;
   logic [31:0] mem [0:63];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.MAX_LOCK(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .r0_req     (r0_req),
      .r0_lock    (r0_lock),
      .r0_addr    (r0_addr),
      .r0_wdata   (r0_wdata),
      .r0_byteen  (r0_byteen),
      .r1_req     (r1_req),
      .r1_lock    (r1_lock),
      .r1_addr    (r1_addr),
      .r1_wdata   (r1_wdata),
      .r1_byteen  (r1_byteen),
      .r0_gnt     (r0_gnt),
      .r1_gnt     (r1_gnt),
      .r0_rvalid  (r0_rvalid),
      .r1_rvalid  (r1_rvalid),
      .r0_rdata   (r0_rdata),
      .r1_rdata   (r1_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_byteen (mem_byteen),
      .mem_rdata  (mem_rdata),
      .owner      (owner)
   );

   // Word-addressed memory: combinational read, byte-lane write at the clock edge.
   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_addr[7:2]] <= pre_data;
      end else begin
         for (int i = 0; i < 4; i++)
            if (mem_byteen[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_req;
      r0_req = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0; r0_byteen = '0;
      r1_req = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0; r1_byteen = '0;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      pre_en = 1; pre_addr = a; pre_data = d;
      step();
      pre_en = 0;
   endtask

   task automatic do_reset;
      clr_req();
      reset = 0;
      step();
      reset = 1;
   endtask

   task automatic test_reset;
      reset = 0;
      r0_req = 1; r0_addr = 32'h10;
      r1_req = 1; r1_addr = 32'h20; r1_byteen = 4'hf;
      step(); step();
      #1;
      checks++; if (r0_gnt !== 1'b0) begin errors++; $display("FAIL rst_r0_gnt: got %b exp 0", r0_gnt); end
      checks++; if (r1_gnt !== 1'b0) begin errors++; $display("FAIL rst_r1_gnt: got %b exp 0", r1_gnt); end
      checks++; if (mem_byteen !== 4'h0) begin errors++; $display("FAIL rst_byteen: got %h exp 0", mem_byteen); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
      checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rst_owner: got %b exp 00", owner); end
      checks++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b exp 00", r0_rvalid, r1_rvalid); end
      checks++; if (r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h %h exp 0 0", r0_rdata, r1_rdata); end
      clr_req();
      reset = 1;
      step();
   endtask

   task automatic test_single_read;
      preload(32'h10, 32'hdeadbeef);
      do_reset();
      r0_req = 1; r0_addr = 32'h13;
      #1;
      checks++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt: got %b%b exp 01", r1_gnt, r0_gnt); end
      checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL rd_mem_addr: got %h exp 00000010", mem_addr); end
      step();
      clr_req();
      checks++; if (r0_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b exp 1", r0_rvalid); end
      checks++; if (r0_rdata !== 32'hdeadbeef) begin errors++; $display("FAIL rd_rdata: got %h exp deadbeef", r0_rdata); end
      step();
      checks++; if (r0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse: got %b exp 0", r0_rvalid); end
      checks++; if (r0_rdata !== 32'hdeadbeef) begin errors++; $display("FAIL rd_rdata_hold: got %h exp deadbeef", r0_rdata); end
   endtask

   task automatic test_simultaneous;
      preload(32'h20, 32'h0);
      do_reset();
      r0_req = 1; r0_addr = 32'h20; r0_byteen = 4'b0011; r0_wdata = 32'h0000abcd;
      r1_req = 1; r1_addr = 32'h20;
      #1;
      checks++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin errors++; $display("FAIL sim_gnt_a: got %b%b exp 01", r1_gnt, r0_gnt); end
      checks++; if (mem_byteen !== 4'b0011 || mem_wdata !== 32'h0000abcd) begin errors++; $display("FAIL sim_wr_bus: got %b %h exp 0011 0000abcd", mem_byteen, mem_wdata); end
      step();
      r0_req = 0; r0_byteen = '0; r0_wdata = '0;
      #1;
      checks++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b1) begin errors++; $display("FAIL sim_gnt_b: got %b%b exp 10", r1_gnt, r0_gnt); end
      checks++; if (r0_rvalid !== 1'b0) begin errors++; $display("FAIL sim_wr_rvalid: got %b exp 0", r0_rvalid); end
      step();
      clr_req();
      checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'h0000abcd) begin errors++; $display("FAIL sim_rd: got %b %h exp 1 0000abcd", r1_rvalid, r1_rdata); end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp0;
      do_reset();
`ifdef DMEM_ARB_RR_EN
      exp0 = 4'b0101;
`else
      exp0 = 4'b1111;
`endif
      r0_req = 1; r0_addr = 32'h10;
      r1_req = 1; r1_addr = 32'h20;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (r0_gnt !== exp0[c] || r1_gnt !== !exp0[c]) begin
            errors++;
            $display("FAIL rr_cycle%0d: got r0=%b r1=%b exp r0=%b r1=%b", c, r0_gnt, r1_gnt, exp0[c], !exp0[c]);
         end
         step();
      end
      clr_req();
   endtask

   task automatic test_lock_forced;
      do_reset();
      r1_req = 1; r1_lock = 1; r1_addr = 32'h20;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin r0_req = 1; r0_addr = 32'h10; end
         #1;
         checks++;
         if (c < 4 && (r1_gnt !== 1'b1 || r0_gnt !== 1'b0)) begin
            errors++; $display("FAIL lock_beat%0d: got r0=%b r1=%b exp r0=0 r1=1", c, r0_gnt, r1_gnt);
         end else if (c == 4 && (r0_gnt !== 1'b1 || r1_gnt !== 1'b0)) begin
            errors++; $display("FAIL lock_release: got r0=%b r1=%b exp r0=1 r1=0", r0_gnt, r1_gnt);
         end
         if (c == 2) begin
            checks++; if (owner !== 2'b10) begin errors++; $display("FAIL lock_owner: got %b exp 10", owner); end
         end
         step();
      end
      clr_req();
   endtask

   task automatic test_lock_release;
      do_reset();
      r0_req = 1; r0_lock = 1; r0_addr = 32'h10;
      #1;
      checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL rel_first: got %b exp 1", r0_gnt); end
      step();
      r0_req = 0; r0_lock = 0;
      r1_req = 1; r1_addr = 32'h20;
      #1;
      checks++; if (owner !== 2'b01) begin errors++; $display("FAIL rel_owner: got %b exp 01", owner); end
      checks++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin errors++; $display("FAIL rel_drop: got %b%b exp 00", r1_gnt, r0_gnt); end
      step();
      #1;
      checks++; if (r1_gnt !== 1'b1 || owner !== 2'b00) begin errors++; $display("FAIL rel_r1: got gnt=%b owner=%b exp 1 00", r1_gnt, owner); end
      step();
      clr_req();
   endtask

   task automatic test_reset_mid;
      preload(32'h10, 32'h12345678);
      do_reset();
      r0_req = 1; r0_addr = 32'h10;
      #1;
      checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b exp 1", r0_gnt); end
      #2;
      reset = 0;
      r0_byteen = 4'hf; r0_wdata = 32'hffffffff;
      step();
      checks++; if (r0_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid: got %b exp 0", r0_rvalid); end
      checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rm_owner: got %b exp 00", owner); end
      checks++; if (mem_byteen !== 4'h0 || r0_gnt !== 1'b0) begin errors++; $display("FAIL rm_byteen: got %h gnt=%b exp 0 0", mem_byteen, r0_gnt); end
      checks++; if (r0_rdata !== 32'h0) begin errors++; $display("FAIL rm_rdata: got %h exp 0", r0_rdata); end
      clr_req();
      reset = 1;
      step();
   endtask

   initial begin
      pre_en = 0; pre_addr = '0; pre_data = '0;
      reset = 0;
      clr_req();
      test_reset();
      test_single_read();
      test_simultaneous();
      test_round_robin();
      test_lock_forced();
      test_lock_release();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
